qos_transmisor: RTL

- Upstream traffic source that drives the write side of the qos block: `vc_id`, `data_word`, `wr_en`.
- Keeps a pending-word count per virtual channel (VC) and sends one word per cycle.
- Picks the VC by round-robin among eligible VCs.
- Obeys the per-VC `pausa`/`continuar` flow control returned by qos, and halts on `error_full`.
- Sits between the test stimulus (or packet generator) and qos; it is the sending end of the qos watermark protocol.

---
 rtl/qos_pkg.sv | 14 +
 rtl/qos_transmisor_if.sv | 37 +++
 rtl/qos_rr_selector.sv | 28 ++
 rtl/qos_transmisor.sv | 130 +++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared constants and FSM encoding for the qos transmitter, its arbiter and benches.
// No logic; default sizing for a 4-VC, 4-bit-payload configuration.
package qos_pkg;
    localparam int DEF_QUEUE_QUANTITY = 4;
    localparam int DEF_BUF_WIDTH      = 3;
    localparam int DEF_MAX_PENDING    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENVIAR = 2'd1,
        ST_ESPERA = 2'd2,
        ST_ERROR  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/qos_transmisor_if.sv
// Control, load, flow-control and qos write-side signals of the transmitter.
// master = transmitter side, slave = stimulus / qos side.
interface qos_transmisor_if
    import qos_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int BUF_WIDTH      = DEF_BUF_WIDTH,
    parameter int MAX_PENDING    = DEF_MAX_PENDING
) ();
    localparam int VW = $clog2(QUEUE_QUANTITY);
    localparam int PW = $clog2(MAX_PENDING) + 1;
    localparam int DW = BUF_WIDTH + 1;

    logic                      enb;
    logic                      iniciar;
    logic                      carga;
    logic [VW-1:0]             carga_vc;
    logic [PW-1:0]             carga_cant;
    logic [QUEUE_QUANTITY-1:0] pausa;
    logic [QUEUE_QUANTITY-1:0] continuar;
    logic [QUEUE_QUANTITY-1:0] error_full;
    logic                      wr_en;
    logic [VW-1:0]             vc_id;
    logic [DW-1:0]             data_word;
    logic [QUEUE_QUANTITY-1:0] pausado;
    logic                      idle;
    logic                      error_tx;

    modport master (
        input  enb, iniciar, carga, carga_vc, carga_cant, pausa, continuar, error_full,
        output wr_en, vc_id, data_word, pausado, idle, error_tx
    );
    modport slave (
        output enb, iniciar, carga, carga_vc, carga_cant, pausa, continuar, error_full,
        input  wr_en, vc_id, data_word, pausado, idle, error_tx
    );
endinterface

// File: rtl/qos_rr_selector.sv
// Combinational round-robin pick: first eligible index strictly after i_ptr, wrapping.
// Zero latency; o_valid low when nothing is eligible.
module qos_rr_selector
    import qos_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    localparam int VW = $clog2(QUEUE_QUANTITY)
) (
    input  logic [QUEUE_QUANTITY-1:0] i_elig,
    input  logic [VW-1:0]             i_ptr,
    output logic [VW-1:0]             o_sel,
    output logic                      o_valid
);
    logic [VW-1:0] w_idx;

    always_comb begin
        w_idx   = '0;
        o_sel   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
            w_idx = VW'((int'(i_ptr) + k) % QUEUE_QUANTITY);
            if (!o_valid && i_elig[w_idx]) begin
                o_valid = 1'b1;
                o_sel   = w_idx;
            end
        end
    end
endmodule

// File: rtl/qos_transmisor.sv
// Per-VC pending-word source feeding qos: round-robin, one word/cycle, 1-edge latency.
// Honours per-VC pausa/continuar immediately; any error_full freezes it until reset.
module qos_transmisor
    import qos_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int BUF_WIDTH      = DEF_BUF_WIDTH,
    parameter int MAX_PENDING    = DEF_MAX_PENDING
) (
    input logic              clk,
    input logic              rst,
    qos_transmisor_if.master bus
);
    localparam int VW = $clog2(QUEUE_QUANTITY);
    localparam int PW = $clog2(MAX_PENDING) + 1;
    localparam int SW = PW + 1;
    localparam int DW = BUF_WIDTH + 1;

    tx_state_e                 r_state, w_state_next;
    logic [PW-1:0]             r_pend      [QUEUE_QUANTITY];
    logic [PW-1:0]             w_pend_next [QUEUE_QUANTITY];
    logic [SW-1:0]             w_sum       [QUEUE_QUANTITY];
    logic [DW-1:0]             r_seq       [QUEUE_QUANTITY];
    logic [VW-1:0]             r_ptr, r_vc_id, w_sel;
    logic [DW-1:0]             r_data_word;
    logic [QUEUE_QUANTITY-1:0] r_pausado, w_pausado_next, w_elig;
    logic                      r_wr_en, r_idle, r_error_tx;
    logic                      w_valid, w_err, w_send, w_load, w_any_pend, w_any_pend_next;

    // Pause is resolved combinationally so a VC paused this cycle is not sent at this edge.
    always_comb begin
        w_pausado_next = bus.pausa | (r_pausado & ~bus.continuar);
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            w_elig[i] = (r_pend[i] != '0) && !w_pausado_next[i];
    end

    assign w_err = |bus.error_full;

    qos_rr_selector #(.QUEUE_QUANTITY(QUEUE_QUANTITY)) u_rr (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_valid (w_valid)
    );

    always_comb begin
        w_send = 1'b0;
        w_load = 1'b0;
        if (!w_err) begin
            w_load = bus.carga && (r_state != ST_ERROR);
            w_send = w_valid && (r_state == ST_ENVIAR || r_state == ST_ESPERA);
        end
    end

    // Load and send on the same VC net out before saturating.
    always_comb begin
        w_any_pend      = 1'b0;
        w_any_pend_next = 1'b0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            w_sum[i] = {1'b0, r_pend[i]};
            if (w_load && bus.carga_vc == VW'(i))
                w_sum[i] = w_sum[i] + {1'b0, bus.carga_cant};
            if (w_send && w_sel == VW'(i))
                w_sum[i] = w_sum[i] - SW'(1);
            w_pend_next[i] = (w_sum[i] > SW'(MAX_PENDING)) ? PW'(MAX_PENDING) : w_sum[i][PW-1:0];
            w_any_pend      |= (r_pend[i] != '0);
            w_any_pend_next |= (w_pend_next[i] != '0);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_err) begin
            w_state_next = ST_ERROR;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (bus.iniciar && w_any_pend) w_state_next = ST_ENVIAR;
                ST_ENVIAR, ST_ESPERA:
                    if (!w_any_pend_next)  w_state_next = ST_IDLE;
                    else if (w_valid)      w_state_next = ST_ENVIAR;
                    else                   w_state_next = ST_ESPERA;
                default:
                    w_state_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_state <= ST_IDLE;
        else if (bus.enb) r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                r_pend[i] <= '0;
                r_seq[i]  <= '0;
            end
            r_ptr       <= VW'(QUEUE_QUANTITY - 1);
            r_wr_en     <= 1'b0;
            r_vc_id     <= '0;
            r_data_word <= '0;
            r_pausado   <= '0;
            r_idle      <= 1'b1;
            r_error_tx  <= 1'b0;
        end else if (bus.enb) begin
            r_wr_en    <= w_send;
            r_pend     <= w_pend_next;
            r_pausado  <= w_pausado_next;
            r_idle     <= (w_state_next == ST_IDLE) && !w_any_pend_next;
            r_error_tx <= (w_state_next == ST_ERROR);
            if (w_send) begin
                r_vc_id      <= w_sel;
                r_data_word  <= r_seq[w_sel];
                r_seq[w_sel] <= r_seq[w_sel] + DW'(1);
                r_ptr        <= w_sel;
            end
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.vc_id     = r_vc_id;
    assign bus.data_word = r_data_word;
    assign bus.pausado   = r_pausado;
    assign bus.idle      = r_idle;
    assign bus.error_tx  = r_error_tx;
endmodule
